// File: rtl/dmem_if.sv
// dmem_if: request/response handshake bundle between a load/store unit and the data memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time word load / byte-masked store RAM with programmable wait states.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_we, r_err, r_resp_err;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata, r_rdata;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_mem [2**ADDR_W];
  logic                w_take, w_access, w_req_err, w_we, w_err;
  logic [ADDR_W-1:0]   w_idx;
  logic [31:0]         w_wdata;
  logic [3:0]          w_wstrb;
  assign w_req_err = (|bus.req_addr[1:0]) | (|(bus.req_addr >> (ADDR_W + 2)));
  // With zero wait states the access happens on the acceptance edge, straight from the bus.
  always_comb begin
    w_take   = r_state == IDLE && bus.req_valid;
    w_access = (w_take && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == 4'd0);
    w_next   = w_access ? RESP : w_take ? WAIT : (r_state == RESP && bus.resp_ready) ? IDLE : r_state;
    w_we     = r_state == IDLE ? bus.req_we : r_we;
    w_err    = r_state == IDLE ? w_req_err : r_err;
    w_idx    = r_state == IDLE ? bus.req_addr[ADDR_W+1:2] : r_idx;
    w_wdata  = r_state == IDLE ? bus.req_wdata : r_wdata;
    w_wstrb  = r_state == IDLE ? bus.req_wstrb : r_wstrb;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_we    <= bus.req_we;
        r_err   <= w_req_err;
        r_idx   <= bus.req_addr[ADDR_W+1:2];
        r_wdata <= bus.req_wdata;
        r_wstrb <= bus.req_wstrb;
        r_cnt   <= 4'(WAIT_CYCLES - 1);
      end else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_access) begin
        r_rdata    <= (w_err || w_we) ? '0 : r_mem[w_idx];
        r_resp_err <= w_err;
      end
    end
  end
  // Reset wins over an access landing on the same edge, so the RAM stays untouched.
  always_ff @(posedge clk)
    if (!rst && w_access && w_we && !w_err)
      for (int i = 0; i < 4; i++)
        if (w_wstrb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  assign bus.req_ready  = r_state == IDLE;
  assign bus.resp_valid = r_state == RESP;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responders (1 and 3 wait states) against a word-array model.
module tb_dmem_responder;
  logic        clk = 1'b0, rst = 1'b1, sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic [31:0] o_resp_rdata;
  logic [31:0] mem [2][256];
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  dmem_if a1 ();
  dmem_if a3 ();
  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(a1));
  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(a3));
  assign a1.req_valid  = req_valid & ~sel;
  assign a3.req_valid  = req_valid & sel;
  assign a1.req_we     = req_we;
  assign a3.req_we     = req_we;
  assign a1.req_addr   = req_addr;
  assign a3.req_addr   = req_addr;
  assign a1.req_wdata  = req_wdata;
  assign a3.req_wdata  = req_wdata;
  assign a1.req_wstrb  = req_wstrb;
  assign a3.req_wstrb  = req_wstrb;
  assign a1.resp_ready = resp_ready;
  assign a3.resp_ready = resp_ready;
  assign o_req_ready   = sel ? a3.req_ready  : a1.req_ready;
  assign o_resp_valid  = sel ? a3.resp_valid : a1.resp_valid;
  assign o_resp_rdata  = sel ? a3.resp_rdata : a1.resp_rdata;
  assign o_resp_err    = sel ? a3.resp_err   : a1.resp_err;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (dut%0d) got=%h exp=%h", tag, sel ? 3 : 1, got, exp);
    end
  endtask
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rd, output logic er);
    er = addr % 4 != 0 || addr >= 32'h400;
    rd = '0;
    if (!er && we) begin
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[sel][addr / 4][8*i +: 8] = wdata[8*i +: 8];
    end else if (!er) rd = mem[sel][addr / 4];
  endtask
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int hold, input bit sticky);
    logic [31:0] erd;
    logic        eer;
    int          n;
    chk("req_ready_idle", 32'(o_req_ready), 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    resp_ready = hold == 0;
    @(posedge clk); #1;
    model(we, addr, wdata, wstrb, erd, eer);
    req_valid = sticky;
    req_addr  = $urandom;
    req_wdata = $urandom;
    chk("req_ready_busy", 32'(o_req_ready), 0);
    n = 0;
    while (!o_resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    chk("latency", 32'(n), sel ? 3 : 1);
    chk("rdata", o_resp_rdata, erd);
    chk("err", 32'(o_resp_err), 32'(eer));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(o_resp_valid), 1);
      chk("bp_rdata", o_resp_rdata, erd);
      chk("bp_err", 32'(o_resp_err), 32'(eer));
      chk("bp_req_ready", 32'(o_req_ready), 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", 32'(o_resp_valid), 0);
    chk("ready_back", 32'(o_req_ready), 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(o_req_ready), 1);
    chk({tag, "_resp_valid"}, 32'(o_resp_valid), 0);
    chk({tag, "_rdata"}, o_resp_rdata, 0);
    chk({tag, "_err"}, 32'(o_resp_err), 0);
  endtask
  task automatic reset_in_wait(input int waits_before);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (waits_before) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("rst_wait");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("rst_wait_noresp", 32'(o_resp_valid), 0);
    end
    do_req(1'b0, 32'h20, 0, 0, 0, 1'b0);
  endtask
  initial begin
    logic [31:0] a;
    int          r;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sel = 1'b0; check_reset_outputs("reset");
    sel = 1'b1; check_reset_outputs("reset");
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 256; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);
    end
    sel = 1'b0;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h10, 0, 0, 0, 1'b0);
    chk("raw_direct", mem[0][4], 32'hDEADBEEF);
    do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 1'b0);
    do_req(1'b0, 32'h10, 0, 0, 0, 1'b0);
    chk("bytemask_direct", mem[0][4], 32'hDE22BE44);
    do_req(1'b0, 32'h12, 0, 0, 0, 1'b0);
    do_req(1'b1, 32'h400, 32'h55AA55AA, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h000, 0, 0, 0, 1'b0);
    do_req(1'b1, 32'h004, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
    do_req(1'b0, 32'h004, 0, 0, 0, 1'b0);
    do_req(1'b0, 32'h10, 0, 0, 5, 1'b0);
    do_req(1'b0, 32'h3FC, 0, 0, 0, 1'b1);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("resp_before_rst", 32'(o_resp_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    check_reset_outputs("rst_resp");
    sel = 1'b1;
    reset_in_wait(1);
    reset_in_wait(2);
    for (int t = 0; t < 400; t++) begin
      sel = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      a = r == 0 ? {22'($urandom_range(0, 255)), 2'($urandom_range(1, 3))} :
          r == 1 ? (($urandom | 32'h400) & ~32'h3) : 32'($urandom_range(0, 15) * 4);
      do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0,
             1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that serves the load/store requests whose addresses the execute-stage ALU computes (lw, sw).
- Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Performs a word read or a byte-masked write into an internal RAM.
- Returns read data or an error flag over a second valid/ready handshake toward the writeback logic.

Parameters:
- ADDR_W, 8, log2 of RAM depth in 32-bit words (256 words, byte addresses 0x000-0x3FF).
- WAIT_CYCLES, 1, wait states between request acceptance and memory access (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address from the ALU result
- req_wdata  input  32  store data
- req_wstrb  input  4  byte enables for stores; bit i selects byte i
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  load data; 0 for stores and errors
- resp_err  output  1  access was misaligned or out of range

Behaviour:
- Reset: synchronous, active-high, takes priority over all other events.
  - State returns to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - RAM contents are not reset.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a clock edge, latch we/addr/wdata/wstrb and decode the error.
  - Error condition: addr[1:0]!=0, or addr[31:ADDR_W+2]!=0.
  - If WAIT_CYCLES=0, go directly to RESP and perform the access on that edge.
  - Otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the edge where the counter is 0, perform the access and go to RESP.
- Access:
  - Load: resp_rdata = RAM[addr[ADDR_W+1:2]].
  - Store: for each i with wstrb[i]=1, RAM byte i is written with wdata[8i+7:8i]; resp_rdata=0.
  - Error: no RAM write, resp_rdata=0, resp_err=1.
  - Store with wstrb=0: no write, no error.
- RESP:
  - resp_valid=1; rdata and err held stable until resp_ready=1 at a clock edge.
  - After that handshake edge: resp_valid=0, go to IDLE, req_ready=1 in the next cycle.
  - No new request is accepted in the handshake cycle, so there are no back-to-back overlaps.
- Latency: a request accepted at edge t gives resp_valid=1 starting at cycle t+1+WAIT_CYCLES, provided resp_ready was not the limiter.
- Throughput: at most one request per 2+WAIT_CYCLES cycles.
- req_ready depends only on state, never combinationally on req_valid.
- Inputs are ignored outside IDLE; req_valid may stay high without causing a second acceptance.
- Reset during WAIT: the pending store is discarded and the RAM is unchanged.
  - Reset arriving on the same edge as the access also discards the access, because reset has priority.
- Reset during RESP: the response is dropped and resp_valid=0 on the next cycle.
- Read-after-write: a load following a store to the same word returns the updated data. The store is committed before its response is issued.
- Address wrap: there is none. Addresses beyond the RAM range report resp_err and never alias.

Test Plan:
1. Reset with WAIT_CYCLES=1: rst high for 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
2. Store then load: store addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF.
   - Response appears 2 cycles after acceptance with err=0, rdata=0.
   - Load addr=0x10 -> resp_rdata=0xDEADBEEF, err=0.
3. Byte mask: over test 2's data, store addr=0x10, wdata=0x11223344, wstrb=4'b0101; then load 0x10 -> 0xDE22BE44.
4. Errors:
   - Load addr=0x12 -> resp_err=1, rdata=0.
   - Store addr=0x400 -> resp_err=1; a follow-up load of 0x000 is unchanged from its prior value.
5. Backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises.
   - resp_valid and rdata stay stable, req_ready=0 throughout.
   - Raise resp_ready -> one handshake, then IDLE with req_ready=1 the next cycle.
6. Reset mid-WAIT with WAIT_CYCLES=3:
   - Store 0xCAFEF00D to 0x20, assert rst during the 2nd wait cycle.
   - Expect no response; a later load of 0x20 returns the prior contents.
